// File: rtl/ahb2apb_bridge_if.sv
// AHB-Lite slave / APB master bus bundle for ahb2apb_bridge.
// PREADY exists only when AHB2APB_WAIT_EN is defined.
interface ahb2apb_bridge_if;
  // AHB-Lite side
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  // APB side
  logic [15:0] PADDR;
  logic        PWRITE;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA0;
  logic [31:0] PRDATA1;
  logic [31:0] PRDATA2;
  logic [31:0] PRDATA3;
`ifdef AHB2APB_WAIT_EN
  logic        PREADY;
`endif

  // Bridge view: AHB slave and APB master.
  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
`ifdef AHB2APB_WAIT_EN
    input  PREADY,
`endif
    output HREADYOUT, HRDATA, HRESP,
    output PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );

  // System view: AHB master and APB peripherals.
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
`ifdef AHB2APB_WAIT_EN
    output PREADY,
`endif
    input  HREADYOUT, HRDATA, HRESP,
    input  PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );
endinterface

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite to 4-slot APB bridge; slot = HADDR[13:12], slot 0 is the tube.
// Define AHB2APB_WAIT_EN to add PREADY-driven wait states in ACCESS.
module ahb2apb_bridge (
  input  logic             clk,
  input  logic             rst_n,
  ahb2apb_bridge_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WLATCH = 2'd1,
    SETUP  = 2'd2,
    ACCESS = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        hreadyout_q, hreadyout_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic [15:0] paddr_q, paddr_d;
  logic        pwrite_q, pwrite_d;
  logic [1:0]  slot_q, slot_d;
  logic [3:0]  psel_q, psel_d;
  logic        penable_q, penable_d;
  logic [31:0] pwdata_q, pwdata_d;

  logic        accept;
  logic        access_done;
  logic [31:0] prdata_sel;

  // Every access is 32-bit and only the low 16 address bits reach APB.
  logic unused_bits;
  assign unused_bits = ^{bus.HSIZE, bus.HADDR[31:16], bus.HTRANS[0]};

  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

`ifdef AHB2APB_WAIT_EN
  assign access_done = bus.PREADY;
`else
  assign access_done = 1'b1;
`endif

  always_comb begin
    unique case (slot_q)
      2'd0:    prdata_sel = bus.PRDATA0;
      2'd1:    prdata_sel = bus.PRDATA1;
      2'd2:    prdata_sel = bus.PRDATA2;
      default: prdata_sel = bus.PRDATA3;
    endcase
  end

  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a variable unassigned,
    // which is what keeps this block from inferring latches.
    state_d     = state_q;
    hreadyout_d = hreadyout_q;
    hrdata_d    = hrdata_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    slot_d      = slot_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwdata_d    = pwdata_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          paddr_d     = bus.HADDR[15:0];
          pwrite_d    = bus.HWRITE;
          slot_d      = bus.HADDR[13:12];
          hreadyout_d = 1'b0;
          if (bus.HWRITE) begin
            state_d = WLATCH;
          end else begin
            // Reads skip WLATCH, so the select is set now to be live in SETUP.
            state_d = SETUP;
            psel_d  = 4'b0001 << bus.HADDR[13:12];
          end
        end
      end
      WLATCH: begin
        pwdata_d = bus.HWDATA;
        psel_d   = 4'b0001 << slot_q;
        state_d  = SETUP;
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (access_done) begin
          psel_d      = 4'b0000;
          penable_d   = 1'b0;
          hreadyout_d = 1'b1;
          state_d     = IDLE;
          if (!pwrite_q) hrdata_d = prdata_sel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hreadyout_q <= 1'b1;
      hrdata_q    <= 32'h0;
      paddr_q     <= 16'h0;
      pwrite_q    <= 1'b0;
      slot_q      <= 2'd0;
      psel_q      <= 4'b0000;
      penable_q   <= 1'b0;
      pwdata_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hrdata_q    <= hrdata_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      slot_q      <= slot_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRDATA    = hrdata_q;
  assign bus.HRESP     = 1'b0;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Scoreboard bench for ahb2apb_bridge: expected APB transfers are queued when
// the AHB address phase is driven and popped when the APB access completes.
module tb_ahb2apb_bridge;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ahb2apb_bridge_if bus ();

  ahb2apb_bridge dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Single AHB slave: the bus HREADY is the bridge's own HREADYOUT.
  assign bus.HREADY = bus.HREADYOUT;

  typedef struct {
    logic [3:0]  psel;
    logic [15:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    int          acc;
  } apb_exp_t;

  apb_exp_t    sb[$];
  int          tests = 0;
  int          fails = 0;
  int          wait_n = 0;
  int          acc_cnt = 0;
  logic [15:0] setup_paddr;
  logic [31:0] setup_pwdata;
  logic [31:0] model_rdata = 32'h0;

  function automatic logic [31:0] prdata_of(input logic [1:0] slot);
    case (slot)
      2'd0:    return 32'h7E6D_5B4F;
      2'd1:    return 32'hCAFE_0001;
      2'd2:    return 32'h2222_BEEF;
      default: return 32'h3333_F00D;
    endcase
  endfunction

  // APB monitor: one-hot select, address/data stability, scoreboard pop.
  always @(negedge clk) begin
    logic done;
    if (!rst_n) begin
      acc_cnt = 0;
    end else begin
      tests++;
      if ($countones(bus.PSEL) > 1) begin
        fails++;
        $display("FAIL psel_onehot: PSEL=%b, required at most one bit", bus.PSEL);
      end
      if (bus.PSEL != 4'b0000 && !bus.PENABLE) begin
        setup_paddr  = bus.PADDR;
        setup_pwdata = bus.PWDATA;
      end
      if (bus.PSEL != 4'b0000 && bus.PENABLE) begin
        acc_cnt++;
        tests++;
        if (bus.PADDR !== setup_paddr || bus.PWDATA !== setup_pwdata) begin
          fails++;
          $display("FAIL apb_stable: PADDR=%h PWDATA=%h, required %h %h from SETUP",
                   bus.PADDR, bus.PWDATA, setup_paddr, setup_pwdata);
        end
`ifdef AHB2APB_WAIT_EN
        bus.PREADY = (acc_cnt > wait_n);
        done = bus.PREADY;
`else
        done = 1'b1;
`endif
        if (done) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL apb_unexpected: PSEL=%b PADDR=%h, required no transfer",
                     bus.PSEL, bus.PADDR);
          end else begin
            apb_exp_t e;
            e = sb.pop_front();
            if (bus.PSEL !== e.psel || bus.PADDR !== e.paddr || bus.PWRITE !== e.pwrite ||
                (e.pwrite && bus.PWDATA !== e.pwdata) || acc_cnt != e.acc) begin
              fails++;
              $display("FAIL apb_xfer: PSEL=%b PADDR=%h PWRITE=%b PWDATA=%h acc=%0d, required %b %h %b %h %0d",
                       bus.PSEL, bus.PADDR, bus.PWRITE, bus.PWDATA, acc_cnt,
                       e.psel, e.paddr, e.pwrite, e.pwdata, e.acc);
            end
          end
          acc_cnt = 0;
        end
      end else begin
        acc_cnt = 0;
`ifdef AHB2APB_WAIT_EN
        bus.PREADY = 1'b0;
`endif
      end
    end
  end

  // Must be entered just after a negedge with HREADYOUT high; returns at the
  // negedge where HREADYOUT is high again, so back-to-back calls chain directly.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input string name);
    apb_exp_t e;
    int lat;
    int exp_lat;
    tests++;
    if (bus.HREADYOUT !== 1'b1) begin
      fails++;
      $display("FAIL %s_ready_in: HREADYOUT=%b, required 1", name, bus.HREADYOUT);
    end
    e.psel   = 4'b0001 << addr[13:12];
    e.paddr  = addr[15:0];
    e.pwrite = wr;
    e.pwdata = wdata;
    e.acc    = wait_n + 1;
    sb.push_back(e);
    exp_lat = (wr ? 4 : 3) + wait_n;

    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = addr;
    bus.HWRITE = wr;
    bus.HSIZE  = 3'b010;
    @(posedge clk);
    #1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = ~wr;
    bus.HADDR  = 32'hFFFF_FFFF;
    bus.HWDATA = wdata;

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.HREADYOUT && lat < 30);
    tests++;
    if (lat != exp_lat) begin
      fails++;
      $display("FAIL %s_latency: %0d cycles, required %0d", name, lat, exp_lat);
    end
    if (!wr) model_rdata = prdata_of(addr[13:12]);
    tests++;
    if (bus.HRDATA !== model_rdata) begin
      fails++;
      $display("FAIL %s_hrdata: HRDATA=%h, required %h", name, bus.HRDATA, model_rdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.HREADYOUT !== 1'b1 || bus.HRDATA !== 32'h0 || bus.HRESP !== 1'b0) begin
      fails++;
      $display("FAIL reset_ahb: HREADYOUT=%b HRDATA=%h HRESP=%b, required 1 0 0",
               bus.HREADYOUT, bus.HRDATA, bus.HRESP);
    end
    tests++;
    if (bus.PADDR !== 16'h0 || bus.PWRITE !== 1'b0 || bus.PSEL !== 4'b0000 ||
        bus.PENABLE !== 1'b0 || bus.PWDATA !== 32'h0) begin
      fails++;
      $display("FAIL reset_apb: PADDR=%h PWRITE=%b PSEL=%b PENABLE=%b PWDATA=%h, required all 0",
               bus.PADDR, bus.PWRITE, bus.PSEL, bus.PENABLE, bus.PWDATA);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    xfer(1'b1, 32'h0000_0000, 32'h1234_5678, "write_tube");
  endtask

  task automatic test_read();
    xfer(1'b0, 32'h0000_1004, 32'h0, "read_slot1");
  endtask

  task automatic test_back_to_back();
    xfer(1'b1, 32'h0000_0004, 32'hA5A5_0004, "b2b_write");
    xfer(1'b0, 32'h0000_3000, 32'h0, "b2b_read");
  endtask

  task automatic test_ignored();
    logic [2:0] pat [3];
    pat[0] = 3'b1_00;
    pat[1] = 3'b1_01;
    pat[2] = 3'b0_10;
    bus.HADDR  = 32'h0000_2000;
    bus.HWRITE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.HSEL   = pat[i][2];
      bus.HTRANS = pat[i][1:0];
      @(negedge clk);
      tests++;
      if (bus.PSEL !== 4'b0000 || bus.HREADYOUT !== 1'b1) begin
        fails++;
        $display("FAIL ignored_%0d: PSEL=%b HREADYOUT=%b, required 0000 1",
                 i, bus.PSEL, bus.HREADYOUT);
      end
    end
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (bus.PSEL !== 4'b0000 || bus.HREADYOUT !== 1'b1) begin
        fails++;
        $display("FAIL ignored_tail: PSEL=%b HREADYOUT=%b, required 0000 1",
                 bus.PSEL, bus.HREADYOUT);
      end
    end
  endtask

  task automatic test_reset_in_access();
    int n;
`ifdef AHB2APB_WAIT_EN
    wait_n = 5;
`else
    begin
      apb_exp_t e;
      e.psel = 4'b0100; e.paddr = 16'h2008; e.pwrite = 1'b0; e.pwdata = 32'h0; e.acc = 1;
      sb.push_back(e);
    end
`endif
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = 32'h0000_2008;
    bus.HWRITE = 1'b0;
    @(posedge clk);
    #1;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.PENABLE && n < 10);
    tests++;
    if (!bus.PENABLE) begin
      fails++;
      $display("FAIL rst_access_reach: PENABLE=%b, required 1", bus.PENABLE);
    end
    #2 rst_n = 1'b0;
    #1;
    model_rdata = 32'h0;
    tests++;
    if (bus.PSEL !== 4'b0000 || bus.PENABLE !== 1'b0 || bus.HREADYOUT !== 1'b1 ||
        bus.HRDATA !== 32'h0) begin
      fails++;
      $display("FAIL rst_access_clear: PSEL=%b PENABLE=%b HREADYOUT=%b HRDATA=%h, required 0000 0 1 0",
               bus.PSEL, bus.PENABLE, bus.HREADYOUT, bus.HRDATA);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    wait_n = 0;
    repeat (6) begin
      @(negedge clk);
      tests++;
      if (bus.PSEL !== 4'b0000 || bus.PENABLE !== 1'b0 || bus.HREADYOUT !== 1'b1) begin
        fails++;
        $display("FAIL rst_no_replay: PSEL=%b PENABLE=%b HREADYOUT=%b, required 0000 0 1",
                 bus.PSEL, bus.PENABLE, bus.HREADYOUT);
      end
    end
  endtask

  task automatic test_mixed();
    xfer(1'b0, 32'h0000_0010, 32'h0, "mix_read0");
    xfer(1'b1, 32'h0000_2ABC, 32'hDEAD_BEEF, "mix_write2");
    xfer(1'b1, 32'h0000_3FFC, 32'h0F0F_F0F0, "mix_write3");
    xfer(1'b0, 32'h0000_2ABC, 32'h0, "mix_read2");
  endtask

`ifdef AHB2APB_WAIT_EN
  task automatic test_wait();
    wait_n = 3;
    xfer(1'b0, 32'h0000_1020, 32'h0, "wait_read");
    wait_n = 1;
    xfer(1'b1, 32'h0000_3008, 32'h5555_AAAA, "wait_write");
    wait_n = 0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    bus.HSEL    = 1'b0;
    bus.HADDR   = 32'h0;
    bus.HTRANS  = 2'b00;
    bus.HWRITE  = 1'b0;
    bus.HSIZE   = 3'b010;
    bus.HWDATA  = 32'h0;
    bus.PRDATA0 = prdata_of(2'd0);
    bus.PRDATA1 = prdata_of(2'd1);
    bus.PRDATA2 = prdata_of(2'd2);
    bus.PRDATA3 = prdata_of(2'd3);

    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_ignored();
    test_reset_in_access();
    test_mixed();
`ifdef AHB2APB_WAIT_EN
    test_wait();
`endif

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d transfers never seen, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
